// File: rtl/udma_tx_l2_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// udma_tx_l2_arbiter_pkg
// Shared definitions for the TX L2 read arbiter:
//   - L2 address/data widths used by the channel requests and the L2 port
//   - datasize encodings for channel reads
//   - id_entry_t, one in-flight read as stored in the ID queue
//   - align_rdata(), which right-aligns and masks a read word for a channel
// ---------------------------------------------------------------------------
package udma_tx_l2_arbiter_pkg;

  localparam int L2_AWIDTH_NOAL = 19;
  localparam int L2_DATA_WIDTH  = 32;

  localparam logic [1:0] DS_BYTE = 2'd0;
  localparam logic [1:0] DS_HALF = 2'd1;
  localparam logic [1:0] DS_WORD = 2'd2;

  // Wide enough for any practical channel count; the top only uses the low bits.
  localparam int ID_WIDTH = 8;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          datasize;
    logic [1:0]          off;
  } id_entry_t;

  // Shift the addressed byte lane down to bit 0, then keep 8/16/32 bits.
  // Encoding 3 is not a legal size and is handled like a word.
  function automatic logic [L2_DATA_WIDTH-1:0] align_rdata(
    input logic [L2_DATA_WIDTH-1:0] rdata,
    input logic [1:0]               datasize,
    input logic [1:0]               off
  );
    logic [L2_DATA_WIDTH-1:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (datasize)
      DS_BYTE: align_rdata = shifted & {{(L2_DATA_WIDTH-8){1'b0}}, 8'hFF};
      DS_HALF: align_rdata = shifted & {{(L2_DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      default: align_rdata = shifted;
    endcase
  endfunction

endpackage

// File: rtl/udma_tx_l2_arbiter_if.sv
// ---------------------------------------------------------------------------
// udma_tx_l2_arbiter_if
// The tx_l2 read port of the uDMA core.
//   req    : read request (master -> slave)
//   gnt    : request accepted (slave -> master)
//   addr   : word-aligned 32-bit byte address (master -> slave)
//   rdata  : read data (slave -> master)
//   rvalid : read data valid, returned in issue order (slave -> master)
// ---------------------------------------------------------------------------
interface udma_tx_l2_arbiter_if;
  import udma_tx_l2_arbiter_pkg::*;

  logic                     req;
  logic                     gnt;
  logic [31:0]              addr;
  logic [L2_DATA_WIDTH-1:0] rdata;
  logic                     rvalid;

  modport master (output req, output addr, input gnt, input rdata, input rvalid);
  modport slave  (input req, input addr, output gnt, output rdata, output rvalid);
endinterface

// File: rtl/udma_tx_l2_arbiter_id_fifo.sv
// ---------------------------------------------------------------------------
// udma_tx_id_fifo
// Synchronous FIFO holding one id_entry_t per outstanding L2 read.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write data_i; accepted when not full, or when full with pop_i
//   pop_i        : drop the head entry; ignored when empty
//   data_i       : entry to write
//   data_o       : head entry (valid while !empty_o)
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module udma_tx_id_fifo
  import udma_tx_l2_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  id_entry_t              data_i,
  output id_entry_t              data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  id_entry_t        mem_q [DEPTH];
  id_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // When full, the head is read from mem_q this cycle, so overwriting the
  // same slot with a simultaneous push is safe.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/udma_tx_l2_arbiter.sv
// ---------------------------------------------------------------------------
// udma_tx_l2_arbiter
// Round-robin sharing of the uDMA tx_l2 read port among N_CH TX channels.
// Issued reads are remembered in an in-order ID queue so that each response
// is steered back to its channel, right-aligned and masked to its datasize.
//   clk_i, rst_i   : core clock, synchronous active-high reset
//   ch_req_i       : per-channel read request, held until granted
//   ch_addr_i      : per-channel byte address
//   ch_datasize_i  : per-channel size (0 byte, 1 half, 2/3 word)
//   ch_gnt_o       : one-hot grant, combinational with l2.gnt
//   ch_valid_o     : one-hot response strobe, one cycle after l2.rvalid
//   ch_data_o      : shared aligned/masked response data
//   l2             : tx_l2 read port (master side)
//   busy_o         : at least one read outstanding
//   err_o          : sticky, a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module udma_tx_l2_arbiter
  import udma_tx_l2_arbiter_pkg::*;
#(
  parameter int N_CH           = 8,
  parameter int L2_AWIDTH_NOAL = udma_tx_l2_arbiter_pkg::L2_AWIDTH_NOAL,
  parameter int L2_DATA_WIDTH  = udma_tx_l2_arbiter_pkg::L2_DATA_WIDTH,
  parameter int MAX_OUTST      = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [N_CH-1:0]                      ch_req_i,
  input  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]  ch_addr_i,
  input  logic [N_CH-1:0][1:0]                 ch_datasize_i,
  output logic [N_CH-1:0]                      ch_gnt_o,
  output logic [N_CH-1:0]                      ch_valid_o,
  output logic [L2_DATA_WIDTH-1:0]             ch_data_o,
  udma_tx_l2_arbiter_if.master                 l2,
  output logic                                 busy_o,
  output logic                                 err_o
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic [SEL_W-1:0]          ptr_q, ptr_d;
  logic [N_CH-1:0]           ch_valid_q, ch_valid_d;
  logic [L2_DATA_WIDTH-1:0]  ch_data_q, ch_data_d;
  logic                      err_q, err_d;

  logic [SEL_W-1:0]          sel;
  logic                      any_req;
  logic [L2_AWIDTH_NOAL-1:0] sel_addr;
  logic [1:0]                sel_ds;
  logic                      gnt_fire;
  logic                      pop;
  id_entry_t                 push_entry;
  id_entry_t                 head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;

  // Round-robin search: first requester at or after ptr_q, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    any_req = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!any_req && ch_req_i[idx]) begin
        any_req = 1'b1;
        sel     = SEL_W'(idx);
      end
    end
  end

  assign sel_addr = ch_addr_i[sel];
  assign sel_ds   = ch_datasize_i[sel];

  // A full queue blocks the request even when a pop frees a slot this cycle.
  assign l2.req   = any_req && !fifo_full;
  assign gnt_fire = l2.req && l2.gnt;

  always_comb begin
    l2.addr                     = '0;
    l2.addr[L2_AWIDTH_NOAL-1:0] = {sel_addr[L2_AWIDTH_NOAL-1:2], 2'b00};
  end

  always_comb begin
    ch_gnt_o = '0;
    if (gnt_fire) begin
      ch_gnt_o[sel] = 1'b1;
    end
  end

  always_comb begin
    push_entry          = '0;
    push_entry.id       = ID_WIDTH'(sel);
    push_entry.datasize = sel_ds;
    push_entry.off      = sel_addr[1:0];
  end

  assign pop = l2.rvalid && !fifo_empty;

  udma_tx_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (gnt_fire),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state for pointer, response register and sticky error.
  always_comb begin
    ptr_d      = ptr_q;
    ch_valid_d = '0;
    ch_data_d  = ch_data_q;
    err_d      = err_q;
    if (gnt_fire) begin
      ptr_d = (sel == SEL_W'(N_CH - 1)) ? '0 : sel + SEL_W'(1);
    end
    if (pop) begin
      for (int i = 0; i < N_CH; i++) begin
        ch_valid_d[i] = (int'(head.id) == i);
      end
      ch_data_d = align_rdata(l2.rdata, head.datasize, head.off);
    end
    if (l2.rvalid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      ch_valid_q <= '0;
      ch_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      ch_valid_q <= ch_valid_d;
      ch_data_q  <= ch_data_d;
      err_q      <= err_d;
    end
  end

  assign ch_valid_o = ch_valid_q;
  assign ch_data_o  = ch_data_q;
  assign err_o      = err_q;
  assign busy_o     = (fifo_count != '0);

endmodule

// File: tb/tb_udma_tx_l2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udma_tx_l2_arbiter
// Drives the arbiter one cycle at a time. A reference model keeps its own
// round-robin pointer and in-flight list; every issued response is pushed to
// a scoreboard queue and compared when the DUT presents it a cycle later.
// ---------------------------------------------------------------------------
module tb_udma_tx_l2_arbiter;
  import udma_tx_l2_arbiter_pkg::*;

  localparam int N_CH      = 8;
  localparam int MAX_OUTST = 4;

  logic                                clk_i = 1'b0;
  logic                                rst_i;
  logic [N_CH-1:0]                     ch_req_i;
  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0] ch_addr_i;
  logic [N_CH-1:0][1:0]                ch_datasize_i;
  logic [N_CH-1:0]                     ch_gnt_o;
  logic [N_CH-1:0]                     ch_valid_o;
  logic [L2_DATA_WIDTH-1:0]            ch_data_o;
  logic                                busy_o;
  logic                                err_o;

  udma_tx_l2_arbiter_if l2_bus ();

  udma_tx_l2_arbiter #(
    .N_CH           (N_CH),
    .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
    .L2_DATA_WIDTH  (L2_DATA_WIDTH),
    .MAX_OUTST      (MAX_OUTST)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ch_req_i      (ch_req_i),
    .ch_addr_i     (ch_addr_i),
    .ch_datasize_i (ch_datasize_i),
    .ch_gnt_o      (ch_gnt_o),
    .ch_valid_o    (ch_valid_o),
    .ch_data_o     (ch_data_o),
    .l2            (l2_bus),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] ch;
    logic [1:0] ds;
    logic [1:0] off;
  } model_entry_t;

  typedef struct packed {
    logic [7:0]  valid;
    logic [31:0] data;
  } resp_t;

  model_entry_t id_model[$];
  resp_t        resp_sb[$];
  int           model_ptr;
  logic         model_err;
  int           assert_count;
  int           fail_count;

  // Expected channel data: pick the addressed lanes out of the read word.
  function automatic logic [31:0] expect_data(input logic [31:0] rdata,
                                              input logic [1:0] ds,
                                              input logic [1:0] off);
    logic [31:0] sh;
    sh = rdata >> (int'(off) * 8);
    case (ds)
      2'd0:    return {24'h0, sh[7:0]};
      2'd1:    return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Single comparison point; counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive at negedge, check registered outputs from the last
  // edge and combinational arbitration, then advance the reference model.
  task automatic applyStimulus(input logic [7:0] req, input logic gnt,
                               input logic rv, input logic [31:0] rdata);
    int           sel;
    logic         found;
    logic         exp_req;
    logic [7:0]   exp_gnt;
    resp_t        r;
    model_entry_t e;

    @(negedge clk_i);
    ch_req_i      = req;
    l2_bus.gnt    = gnt;
    l2_bus.rvalid = rv;
    l2_bus.rdata  = rdata;
    #1;

    if (resp_sb.size() > 0) begin
      r = resp_sb.pop_front();
      checkOutput("ch_valid", 32'(ch_valid_o), 32'(r.valid));
      checkOutput("ch_data", ch_data_o, r.data);
    end else begin
      checkOutput("ch_valid_idle", 32'(ch_valid_o), 32'h0);
    end
    checkOutput("busy", 32'(busy_o), 32'(id_model.size() != 0));
    checkOutput("err", 32'(err_o), 32'(model_err));

    sel   = 0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      int c;
      c = (model_ptr + i) % N_CH;
      if (!found && req[c]) begin
        found = 1'b1;
        sel   = c;
      end
    end
    exp_req = found && (id_model.size() < MAX_OUTST);
    checkOutput("l2_req", 32'(l2_bus.req), 32'(exp_req));
    if (exp_req) begin
      checkOutput("l2_addr", l2_bus.addr, 32'(ch_addr_i[sel]) & 32'hFFFF_FFFC);
    end
    exp_gnt = (exp_req && gnt) ? 8'(1 << sel) : 8'h00;
    checkOutput("ch_gnt", 32'(ch_gnt_o), 32'(exp_gnt));

    if (rv) begin
      if (id_model.size() > 0) begin
        e       = id_model.pop_front();
        r.valid = 8'(1 << e.ch);
        r.data  = expect_data(rdata, e.ds, e.off);
        resp_sb.push_back(r);
      end else begin
        model_err = 1'b1;
      end
    end
    if (exp_req && gnt) begin
      e.ch  = 8'(sel);
      e.ds  = ch_datasize_i[sel];
      e.off = ch_addr_i[sel][1:0];
      id_model.push_back(e);
      model_ptr = (sel + 1) % N_CH;
    end
  endtask

  // Two cycles of reset with hold_req still asserted and the L2 port idle.
  task automatic applyReset(input logic [7:0] hold_req);
    @(negedge clk_i);
    rst_i         = 1'b1;
    ch_req_i      = hold_req;
    l2_bus.gnt    = 1'b0;
    l2_bus.rvalid = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    id_model.delete();
    resp_sb.delete();
    model_ptr = 0;
    model_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    assert_count  = 0;
    fail_count    = 0;
    model_ptr     = 0;
    model_err     = 1'b0;
    rst_i         = 1'b1;
    ch_req_i      = '0;
    l2_bus.gnt    = 1'b0;
    l2_bus.rvalid = 1'b0;
    l2_bus.rdata  = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_addr_i[i]     = L2_AWIDTH_NOAL'(32'h1000 * i + 4 * i + (i % 4));
      ch_datasize_i[i] = 2'(i % 3);
    end

    applyReset(8'h00);
    #1;
    checkOutput("rst_ch_data", ch_data_o, 32'h0);
    checkOutput("rst_ch_valid", 32'(ch_valid_o), 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);
    checkOutput("rst_err", 32'(err_o), 32'h0);
    checkOutput("rst_l2_req", 32'(l2_bus.req), 32'h0);

    // All channels requesting, grant every cycle, each read answered next cycle.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(8'hFF, 1'b1, k > 0, $urandom);
    end
    applyStimulus(8'h00, 1'b0, 1'b1, $urandom);
    applyStimulus(8'h00, 1'b0, 1'b0, 32'h0);

    // ch3 half-word read at 0x102.
    ch_addr_i[3]     = L2_AWIDTH_NOAL'(32'h102);
    ch_datasize_i[3] = 2'd1;
    applyStimulus(8'h08, 1'b1, 1'b0, 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b1, 32'hAABBCCDD);
    applyStimulus(8'h00, 1'b0, 1'b0, 32'h0);
    checkOutput("ch3_valid", 32'(ch_valid_o), 32'h0000_0008);
    checkOutput("ch3_data", ch_data_o, 32'h0000AABB);

    // Responses withheld until the queue fills.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'hFF, 1'b1, 1'b0, 32'h0);
    end
    checkOutput("full_busy", 32'(busy_o), 32'h1);
    checkOutput("full_req_low", 32'(l2_bus.req), 32'h0);
    applyStimulus(8'hFF, 1'b1, 1'b1, $urandom);
    applyStimulus(8'hFF, 1'b1, 1'b0, 32'h0);
    checkOutput("resume_req", 32'(l2_bus.req), 32'h1);

    // Full queue, then grant and response together every cycle.
    applyStimulus(8'hFF, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(8'hFF, 1'b1, 1'b1, $urandom);
    end
    for (int k = 0; k < MAX_OUTST + 1 && id_model.size() > 0; k++) begin
      applyStimulus(8'h00, 1'b0, 1'b1, $urandom);
    end
    applyStimulus(8'h00, 1'b0, 1'b0, 32'h0);
    checkOutput("drained_busy", 32'(busy_o), 32'h0);

    // Response with nothing outstanding.
    applyStimulus(8'h00, 1'b0, 1'b1, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 32'h0);
    end
    checkOutput("err_sticky", 32'(err_o), 32'h1);
    applyReset(8'h00);
    #1;
    checkOutput("err_cleared", 32'(err_o), 32'h0);

    // ch5 byte read at 0x7.
    ch_addr_i[5]     = L2_AWIDTH_NOAL'(32'h7);
    ch_datasize_i[5] = 2'd0;
    applyStimulus(8'h20, 1'b1, 1'b0, 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b1, 32'h5A123456);
    applyStimulus(8'h00, 1'b0, 1'b0, 32'h0);
    checkOutput("ch5_byte", ch_data_o, 32'h0000005A);

    // Move the pointer past ch2, then reset with ch5 still requesting.
    applyStimulus(8'h04, 1'b1, 1'b0, 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b1, $urandom);
    applyStimulus(8'h00, 1'b0, 1'b0, 32'h0);
    applyReset(8'h20);
    applyStimulus(8'h21, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_ptr_ch0", 32'(ch_gnt_o), 32'h0000_0001);
    applyStimulus(8'h00, 1'b0, 1'b1, $urandom);
    applyStimulus(8'h00, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
